// File: rtl/rv_core_pkg.sv
// Shared core-wide constants for the instruction-fetch path.
package rv_core_pkg;

  localparam int unsigned INST_SIZE  = 32;
  localparam int unsigned PC_SIZE    = 32;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] NOP        = 32'h0000_0013;  // addi x0, x0, 0
  localparam int unsigned INST_BYTES = 4;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO holding fetched {pc, inst} pairs; flush beats push and pop.
module fetch_queue #(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [Width-1:0]         wdata_i,
  output logic [Width-1:0]         rdata_o,
  output logic [$clog2(Depth):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned CW = AW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Guard against overflow/underflow; a pop frees a slot for a same-cycle push.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Next-state for pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push && !do_pop) begin
        count_d = count_q + CW'(1);
      end else if (!do_push && do_pop) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  // Pointer and occupancy registers; reset empties the queue immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only observed through a nonzero count, so no reset.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: owns the PC, queues fetched words, handles execute redirects.
module fetch_unit
  import rv_core_pkg::*;
#(
  parameter int unsigned          INST_SIZE  = rv_core_pkg::INST_SIZE,
  parameter int unsigned          PC_SIZE    = rv_core_pkg::PC_SIZE,
  parameter logic [PC_SIZE-1:0]   RESET_PC   = rv_core_pkg::RESET_PC,
  parameter int unsigned          FIFO_DEPTH = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          fetch_en_i,
  input  logic                          redirect_valid_i,
  input  logic [PC_SIZE-1:0]            redirect_pc_i,
  output logic [PC_SIZE-1:0]            imem_pc_o,
  input  logic [INST_SIZE-1:0]          imem_inst_i,
  output logic                          dec_valid_o,
  input  logic                          dec_ready_i,
  output logic [INST_SIZE-1:0]          dec_inst_o,
  output logic [PC_SIZE-1:0]            dec_pc_o,
  output logic [PC_SIZE-1:0]            dec_pc_plus4_o,
  output logic                          misalign_err_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam int unsigned EntryW = PC_SIZE + INST_SIZE;

  logic [PC_SIZE-1:0] pc_q, pc_d;
  logic               misalign_q, misalign_d;
  logic               pop, push, can_push;
  logic               q_full, q_empty;
  logic [EntryW-1:0]  q_rdata;

  assign imem_pc_o   = pc_q;
  assign dec_valid_o = ~q_empty;

  assign pop      = dec_valid_o & dec_ready_i;
  assign can_push = ~q_full | pop;
  assign push     = fetch_en_i & can_push & ~redirect_valid_i;

  fetch_queue #(
    .Width (EntryW),
    .Depth (FIFO_DEPTH)
  ) u_fetch_queue (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .pop_i   (pop & ~redirect_valid_i),
    .flush_i (redirect_valid_i),
    .wdata_i ({pc_q, imem_inst_i}),
    .rdata_o (q_rdata),
    .count_o (fifo_count_o),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  // Present the head, or a NOP at PC 0 while the queue is empty.
  always_comb begin
    dec_inst_o = INST_SIZE'(NOP);
    dec_pc_o   = '0;
    if (dec_valid_o) begin
      dec_inst_o = q_rdata[INST_SIZE-1:0];
      dec_pc_o   = q_rdata[INST_SIZE +: PC_SIZE];
    end
    dec_pc_plus4_o = dec_pc_o + PC_SIZE'(INST_BYTES);
  end

  // PC advance and redirect arbitration; redirect wins and drops the low two bits.
  always_comb begin
    pc_d       = pc_q;
    misalign_d = misalign_q;
    if (redirect_valid_i) begin
      pc_d = {redirect_pc_i[PC_SIZE-1:2], 2'b00};
      if (redirect_pc_i[1:0] != 2'b00) misalign_d = 1'b1;
    end else if (push) begin
      pc_d = pc_q + PC_SIZE'(INST_BYTES);
    end
  end

  // PC and sticky misalignment flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  assign misalign_err_o = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a combinational IMEM model (word = pc ^ 0x13579BDF).
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_pc;
  logic [31:0] imem_inst;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
  logic [31:0] dec_pc_plus4;
  logic        misalign_err;
  logic [1:0]  fifo_count;

  int n_total = 0;
  int n_pass  = 0;

  localparam logic [31:0] NopW = 32'h0000_0013;

  always #5 clk = ~clk;

  assign imem_inst = imem_pc ^ 32'h1357_9BDF;

  fetch_unit dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .fetch_en_i       (fetch_en),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .imem_pc_o        (imem_pc),
    .imem_inst_i      (imem_inst),
    .dec_valid_o      (dec_valid),
    .dec_ready_i      (dec_ready),
    .dec_inst_o       (dec_inst),
    .dec_pc_o         (dec_pc),
    .dec_pc_plus4_o   (dec_pc_plus4),
    .misalign_err_o   (misalign_err),
    .fifo_count_o     (fifo_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n          = 1'b0;
    fetch_en       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    dec_ready      = 1'b0;
    #2;
    check("rst_imem_pc", imem_pc, 32'h0);
    check("rst_valid", {31'b0, dec_valid}, 32'h0);
    check("rst_inst", dec_inst, NopW);
    check("rst_pc", dec_pc, 32'h0);
    check("rst_pc4", dec_pc_plus4, 32'h4);
    check("rst_count", {30'b0, fifo_count}, 32'h0);
    check("rst_mis", {31'b0, misalign_err}, 32'h0);

    // Streaming fetch with decode always ready.
    #1;
    rst_n = 1'b1; fetch_en = 1'b1; dec_ready = 1'b1;
    check("s0_imem", imem_pc, 32'h0);
    tick();
    check("s1_imem", imem_pc, 32'h4);
    check("s1_pc", dec_pc, 32'h0);
    check("s1_inst", dec_inst, 32'h1357_9BDF);
    check("s1_pc4", dec_pc_plus4, 32'h4);
    check("s1_count", {30'b0, fifo_count}, 32'h1);
    tick();
    check("s2_imem", imem_pc, 32'h8);
    check("s2_pc", dec_pc, 32'h4);
    check("s2_inst", dec_inst, 32'h1357_9BDB);
    tick();
    check("s3_imem", imem_pc, 32'hC);
    check("s3_pc", dec_pc, 32'h8);
    check("s3_inst", dec_inst, 32'h1357_9BD7);
    check("s3_pc4", dec_pc_plus4, 32'hC);

    // Restart from reset, then hold off decode for five cycles.
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1; dec_ready = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("bp_count", {30'b0, fifo_count}, 32'h2);
    check("bp_imem", imem_pc, 32'h8);
    check("bp_pc", dec_pc, 32'h0);
    check("bp_inst", dec_inst, 32'h1357_9BDF);
    dec_ready = 1'b1;
    check("rel0_pc", dec_pc, 32'h0);
    tick();
    check("rel1_pc", dec_pc, 32'h4);
    check("rel1_count", {30'b0, fifo_count}, 32'h2);
    tick();
    check("rel2_pc", dec_pc, 32'h8);
    check("rel2_valid", {31'b0, dec_valid}, 32'h1);
    check("rel2_imem", imem_pc, 32'h10);

    // Redirect with a full queue and decode ready: head is dropped, not consumed.
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    check("rd_count", {30'b0, fifo_count}, 32'h0);
    check("rd_valid", {31'b0, dec_valid}, 32'h0);
    check("rd_inst", dec_inst, NopW);
    check("rd_imem", imem_pc, 32'h100);
    tick();
    check("rd2_pc", dec_pc, 32'h100);
    check("rd2_inst", dec_inst, 32'h1357_9ADF);
    check("rd2_imem", imem_pc, 32'h104);

    // Misaligned target is truncated and flagged; the flag is sticky.
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    tick();
    check("mis_flag", {31'b0, misalign_err}, 32'h1);
    check("mis_imem", imem_pc, 32'h100);
    redirect_pc = 32'h200;
    tick();
    check("mis_sticky", {31'b0, misalign_err}, 32'h1);
    check("al_imem", imem_pc, 32'h200);

    // PC wraps modulo 2^32.
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    check("wr0_imem", imem_pc, 32'hFFFF_FFFC);
    tick();
    check("wr1_imem", imem_pc, 32'h0);
    check("wr1_pc", dec_pc, 32'hFFFF_FFFC);
    check("wr1_inst", dec_inst, 32'hECA8_6423);
    check("wr1_pc4", dec_pc_plus4, 32'h0);
    tick();
    check("wr2_imem", imem_pc, 32'h4);
    check("wr2_pc", dec_pc, 32'h0);
    check("wr2_mis", {31'b0, misalign_err}, 32'h1);

    // Fill the queue, then assert reset between clock edges.
    dec_ready = 1'b0;
    tick(); tick(); tick();
    check("pre_ar_count", {30'b0, fifo_count}, 32'h2);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", {31'b0, dec_valid}, 32'h0);
    check("ar_imem", imem_pc, 32'h0);
    check("ar_count", {30'b0, fifo_count}, 32'h0);
    check("ar_inst", dec_inst, NopW);
    check("ar_mis", {31'b0, misalign_err}, 32'h0);
    #1 rst_n = 1'b1; dec_ready = 1'b1;
    check("res0_imem", imem_pc, 32'h0);
    tick();
    check("res1_pc", dec_pc, 32'h0);
    check("res1_imem", imem_pc, 32'h4);

    // Fetch disabled: queue drains, PC holds.
    fetch_en = 1'b0;
    tick();
    check("fe_valid", {31'b0, dec_valid}, 32'h0);
    check("fe_imem", imem_pc, 32'h4);
    tick();
    check("fe_imem2", imem_pc, 32'h4);
    check("fe_count", {30'b0, fifo_count}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end that sits directly upstream of the combinational byte-addressed instruction memory.
- Owns the program counter and drives the memory address. Captures the returned 32-bit word together with its PC into a small instruction queue, and presents it to decode with a valid/ready handshake.
- Handles control-flow redirects from execute by flushing the queue and reloading the PC.

Parameters:
- INST_SIZE, 32, instruction width in bits
- PC_SIZE, 32, PC / address width in bits
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- FIFO_DEPTH, 2, instruction queue entries; power of two, ≥2

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- fetch_en  in  1  fetch enable; low = hold PC, no new pushes
- redirect_valid  in  1  branch/jump taken this cycle
- redirect_pc  in  PC_SIZE  redirect target byte address
- imem_pc  out  PC_SIZE  address to instruction memory (= pc_q)
- imem_inst  in  INST_SIZE  instruction word returned combinationally for imem_pc
- dec_valid  out  1  queue head holds a valid instruction
- dec_ready  in  1  decode accepts head this cycle
- dec_inst  out  INST_SIZE  head instruction
- dec_pc  out  PC_SIZE  head instruction's PC
- dec_pc_plus4  out  PC_SIZE  dec_pc + 4 (link value)
- misalign_err  out  1  sticky: a redirect target had a nonzero value in bits [1:0]
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy (debug)

Behaviour:
- Reset (async assert, sync deassert is handled externally):
  - pc_q = RESET_PC
  - queue empty, fifo_count = 0
  - dec_valid = 0
  - dec_inst = 32'h0000_0013 (NOP); dec_pc = 0; dec_pc_plus4 = 4
  - misalign_err = 0
  - Reset asserted mid-operation discards all queue contents immediately.
- imem_pc = pc_q, combinationally. imem_inst is treated as valid in the same cycle.
- Definitions:
  - pop = dec_valid & dec_ready
  - can_push = (count < FIFO_DEPTH) | pop
  - push = fetch_en & can_push & ~redirect_valid
- On push:
  - Write {pc_q, imem_inst} at the tail.
  - pc_q <= pc_q + 4, modulo 2^PC_SIZE (32'hFFFF_FFFC wraps to 0).
- On pop:
  - Advance the head.
  - Push and pop in the same cycle while full is legal; count is unchanged.
- No push:
  - pc_q holds. This covers a full queue with no pop, and fetch_en = 0.
- Redirect (highest priority, overrides push and pop):
  - Queue flushed (count <= 0); the head is NOT consumed even if dec_ready = 1.
  - pc_q <= {redirect_pc[PC_SIZE-1:2], 2'b00}.
  - If redirect_pc[1:0] != 0, misalign_err <= 1; it stays set until reset.
- Latency:
  - A word fetched at cycle N appears on dec_* at N+1 (queue output is registered/head read).
  - A redirect at cycle N gives imem_pc = target at N+1 and the first dec_valid for the target at N+2.
- dec_* stability:
  - While dec_valid = 1 and dec_ready = 0, dec_inst, dec_pc and dec_pc_plus4 hold stable.
  - When dec_valid = 0, dec_inst = NOP.
- Sustained throughput: 1 instruction/cycle with dec_ready held high.
- fetch_en low:
  - The queue still drains.
  - imem_pc holds.
  - No fetch is recorded.

Decomposition:
- Shared package rv_core_pkg holds:
  - INST_SIZE, PC_SIZE, RESET_PC
  - NOP encoding 32'h0000_0013
  - INST_BYTES = 4
- One sub-module: fetch_queue, a synchronous FIFO with:
  - width PC_SIZE + INST_SIZE, depth FIFO_DEPTH
  - push, pop, flush, count
  - full/empty derived from count
  - flush has priority over push and pop
- PC logic and redirect arbitration stay in fetch_unit.

Test Plan:
- Reset then fetch_en = 1, dec_ready = 1, IMEM preloaded 0x00..0x0C:
  - imem_pc = 0, 4, 8, C on consecutive cycles.
  - dec_pc = 0, 4, 8 from cycle 1 with matching words.
  - dec_pc_plus4 = dec_pc + 4.
- Backpressure: dec_ready = 0 for 5 cycles:
  - fifo_count saturates at 2 and imem_pc freezes at 8.
  - dec_inst/dec_pc stay at PC 0.
  - On release, PCs 0, 4, 8 are delivered in order with no gap and no duplicate.
- Redirect to 0x100 while the queue holds 2 entries and dec_ready = 1:
  - Next cycle fifo_count = 0, dec_valid = 0, imem_pc = 0x100.
  - Following cycle dec_pc = 0x100.
- Redirect to 0x102:
  - misalign_err = 1, imem_pc = 0x100.
  - Later aligned redirects leave misalign_err = 1 until rst_n pulses low.
- Wrap: redirect to 0xFFFF_FFFC:
  - imem_pc sequence FFFF_FFFC, 0000_0000, 0000_0004.
  - dec_pc_plus4 for the first word = 0.
- Async reset asserted mid-stream with the queue full:
  - Outputs go to reset values without a clock edge: dec_valid = 0, imem_pc = RESET_PC.
  - Fetching resumes at RESET_PC after deassertion.
